// File: rtl/cas_pkg.sv
// Shared types and constants for the cassette FSK transmitter.
package cas_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } cas_state_e;

  localparam int          TIMER_W     = 15;
  localparam int          HALF0_DEF   = 17898;
  localparam int          HALF1_DEF   = 8949;
  localparam logic [7:0]  LEADER_BYTE = 8'h55;

  // Half-period length in clocks for a given bit value.
  function automatic logic [TIMER_W-1:0] half_len(input logic bit_val,
                                                  input int   h0,
                                                  input int   h1);
    return bit_val ? TIMER_W'(h1) : TIMER_W'(h0);
  endfunction

endpackage

// File: rtl/cas_halfper_timer.sv
// Loadable 15-bit half-period down-counter; counts only while enabled and
// pulses o_expire on the enabled clock that finishes the loaded count.
module cas_halfper_timer
  import cas_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic [TIMER_W-1:0] i_load_val,
  input  logic               i_en,
  output logic               o_expire
);

  logic [TIMER_W-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_expire = i_en && (r_count == TIMER_W'(1));

endmodule

// File: rtl/cas_fsk_tx.sv
// Double-buffered 1200/2400 Hz cassette FSK transmitter, LSB first.
// Define CAS_LEADER_EN to send repeating 0x55 leader bytes while no data is queued.
module cas_fsk_tx
  import cas_pkg::*;
#(
  parameter int HALF0 = HALF0_DEF,
  parameter int HALF1 = HALF1_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  input  logic       motor,
  output logic       casdout,
  output logic       busy
);

  cas_state_e         r_state;
  logic [7:0]         r_hold;
  logic               r_hold_full;
  logic [7:0]         r_shift;
  logic [2:0]         r_bit_idx;
  logic               r_casdout;

  logic               w_expire;
  logic               w_tload;
  logic [TIMER_W-1:0] w_tval;
  logic               w_load_byte;
  logic               w_src_avail;
  logic [7:0]         w_src_byte;

`ifdef CAS_LEADER_EN
  assign w_src_avail = 1'b1;
  assign w_src_byte  = r_hold_full ? r_hold : LEADER_BYTE;
`else
  assign w_src_avail = r_hold_full;
  assign w_src_byte  = r_hold;
`endif

  cas_halfper_timer u_timer (
    .i_clk      (clk),
    .i_rst      (reset),
    .i_load     (w_tload),
    .i_load_val (w_tval),
    .i_en       (motor && (r_state != IDLE)),
    .o_expire   (w_expire)
  );

  // Timer reload and byte-load decisions for the current state.
  always_comb begin
    w_tload     = 1'b0;
    w_tval      = '0;
    w_load_byte = 1'b0;
    case (r_state)
      IDLE: begin
        if (motor && w_src_avail) begin
          w_tload     = 1'b1;
          w_tval      = half_len(w_src_byte[0], HALF0, HALF1);
          w_load_byte = 1'b1;
        end
      end
      HIGH: begin
        if (w_expire) begin
          w_tload = 1'b1;
          w_tval  = half_len(r_shift[r_bit_idx], HALF0, HALF1);
        end
      end
      LOW: begin
        if (w_expire) begin
          if (r_bit_idx != 3'd7) begin
            w_tload = 1'b1;
            w_tval  = half_len(r_shift[r_bit_idx + 3'd1], HALF0, HALF1);
          end else if (w_src_avail) begin
            w_tload     = 1'b1;
            w_tval      = half_len(w_src_byte[0], HALF0, HALF1);
            w_load_byte = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Payload of the holding register carries no reset; hold_full qualifies it.
  always_ff @(posedge clk) begin
    if (data_valid && !r_hold_full) begin
      r_hold <= data_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_hold_full <= 1'b0;
      r_shift     <= '0;
      r_bit_idx   <= '0;
      r_casdout   <= 1'b0;
    end else begin
      // Output lags the state by one clock so each half spans exactly HALFn clocks.
      r_casdout <= motor && (r_state == HIGH);

      if (data_valid && !r_hold_full) begin
        r_hold_full <= 1'b1;
      end else if (w_load_byte && r_hold_full) begin
        r_hold_full <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (w_load_byte) begin
            r_shift   <= w_src_byte;
            r_bit_idx <= '0;
            r_state   <= HIGH;
          end
        end
        HIGH: begin
          if (w_expire) begin
            r_state <= LOW;
          end
        end
        LOW: begin
          if (w_expire) begin
            if (r_bit_idx != 3'd7) begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_state   <= HIGH;
            end else if (w_load_byte) begin
              r_shift   <= w_src_byte;
              r_bit_idx <= '0;
              r_state   <= HIGH;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign data_ready = ~r_hold_full;
  assign busy       = r_hold_full | (r_state != IDLE);
  assign casdout    = r_casdout;

endmodule

// File: tb/tb_cas_fsk_tx.sv
// Scoreboard bench for cas_fsk_tx with HALF0=4, HALF1=2; timing is modelled in
// "motor time" (only clocks sampled with motor=1 advance the transmission).
module tb_cas_fsk_tx;

  localparam int H0 = 4;
  localparam int H1 = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       data_valid = 1'b0;
  logic       data_ready;
  logic       motor = 1'b0;
  logic       casdout;
  logic       busy;

  cas_fsk_tx #(.HALF0(H0), .HALF1(H1)) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .motor      (motor),
    .casdout    (casdout),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int s;
    int f;
  } hi_t;

  hi_t q[$];
  int  model_end = 0;
  int  mt = 0;
  int  n_chk = 0;
  int  n_fail = 0;
  bit  have_pend = 0;
  int  pend_f = 0;
  bit  sb_en = 1;
  logic prev = 1'b0;

  // Each byte starts one motor-clock after acceptance or right at the end of the
  // previous byte, whichever is later; every bit is a high half then a low half.
  function automatic void model_push(input logic [7:0] b, input int m);
    int l;
    int h;
    l = (m + 1 > model_end) ? m + 1 : model_end;
    for (int i = 0; i < 8; i++) begin
      h = b[i] ? H1 : H0;
      q.push_back('{s: l + 1, f: l + h + 1});
      l += 2 * h;
    end
    model_end = l;
  endfunction

  task automatic check(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // Monitor: compares every casdout edge against the queued expectation.
  always begin
    hi_t e;
    @(posedge clk);
    #1;
    if (reset) begin
      prev      = 1'b0;
      have_pend = 0;
    end else if (!motor) begin
      n_chk++;
      if (casdout !== 1'b0) begin
        n_fail++;
        $display("FAIL motor_off_level: got %b expected 0", casdout);
      end
    end else begin
      mt++;
      if (sb_en && casdout === 1'b1 && prev === 1'b0) begin
        n_chk++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_rise: rise at motor clock %0d with nothing queued", mt);
        end else begin
          e = q.pop_front();
          if (mt != e.s) begin
            n_fail++;
            $display("FAIL rise_time: got motor clock %0d expected %0d", mt, e.s);
          end
          pend_f    = e.f;
          have_pend = 1;
        end
      end else if (sb_en && casdout === 1'b0 && prev === 1'b1) begin
        n_chk++;
        if (!have_pend) begin
          n_fail++;
          $display("FAIL unexpected_fall: fall at motor clock %0d", mt);
        end else if (mt != pend_f) begin
          n_fail++;
          $display("FAIL fall_time: got motor clock %0d expected %0d", mt, pend_f);
        end
        have_pend = 0;
      end
      prev = casdout;
    end
  end

  task automatic send(input logic [7:0] b, input bit rnd);
    int n;
    n = 0;
    data_in    = b;
    data_valid = 1'b1;
    if (rnd) motor = ($urandom_range(0, 4) != 0);
    while (!data_ready && n < 4000) begin
      @(negedge clk);
      n++;
      if (rnd) motor = ($urandom_range(0, 4) != 0);
    end
    n_chk++;
    if (!data_ready) begin
      n_fail++;
      $display("FAIL send_timeout: data_ready got %b expected 1", data_ready);
    end else begin
      model_push(b, mt + (motor ? 1 : 0));
    end
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || have_pend) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    n_chk++;
    if (q.size() != 0 || have_pend) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d halves outstanding expected 0", q.size());
    end
    repeat (H0 + 2) @(negedge clk);
    check("idle_busy", busy, 1'b0);
    check("idle_casdout", casdout, 1'b0);
  endtask

  initial begin
    int run;
    int len;
    int n;
    logic [7:0] lb;

    repeat (3) @(negedge clk);
    check("reset_casdout", casdout, 1'b0);
    check("reset_data_ready", data_ready, 1'b1);
    check("reset_busy", busy, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check("release_casdout", casdout, 1'b0);
    check("release_data_ready", data_ready, 1'b1);
    check("release_busy", busy, 1'b0);

`ifdef CAS_LEADER_EN
    sb_en = 0;
    motor = 1'b1;
    lb    = 8'h55;
    n     = 0;
    while (casdout !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("leader_start", casdout, 1'b1);
    for (run = 0; run < 8; run++) begin
      len = 0;
      while (casdout === ((run % 2 == 0) ? 1'b1 : 1'b0) && len < 20) begin
        @(negedge clk);
        len++;
      end
      n_chk++;
      if (len != (lb[run / 2] ? H1 : H0)) begin
        n_fail++;
        $display("FAIL leader_run%0d: got %0d clocks expected %0d", run, len, lb[run / 2] ? H1 : H0);
      end
    end
`else
    // Single byte 0x01 from idle.
    motor = 1'b1;
    send(8'h01, 0);
    drain();

    // Back-to-back 0xAA then 0x55.
    send(8'hAA, 0);
    check("ready_after_accept", data_ready, 1'b0);
    @(negedge clk);
    check("ready_after_load", data_ready, 1'b1);
    send(8'h55, 0);
    drain();

    // Motor drop of 10 clocks inside a 0-bit high half.
    send(8'h00, 0);
    repeat (4) @(negedge clk);
    check("drop_pre_high", casdout, 1'b1);
    motor = 1'b0;
    repeat (10) @(negedge clk);
    motor = 1'b1;
    @(negedge clk);
    check("resume_high", casdout, 1'b1);
    @(negedge clk);
    check("resume_low", casdout, 1'b0);
    drain();

    // Randomized bytes with random gaps and motor interruptions.
    for (int k = 0; k < 16; k++) begin
      n = $urandom_range(0, 12);
      for (int g = 0; g < n; g++) begin
        motor = ($urandom_range(0, 4) != 0);
        @(negedge clk);
      end
      send(8'($urandom_range(0, 255)), 1);
    end
    motor = 1'b1;
    drain();

    // Reset mid-byte with the holding register full.
    send(8'h00, 0);
    send(8'h0F, 0);
    n = 0;
    while (casdout !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("pre_reset_high", casdout, 1'b1);
    reset = 1'b1;
    #1;
    check("async_reset_casdout", casdout, 1'b0);
    check("async_reset_ready", data_ready, 1'b1);
    check("async_reset_busy", busy, 1'b0);
    q.delete();
    model_end = 0;
    have_pend = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    check("post_reset_casdout", casdout, 1'b0);
    check("post_reset_busy", busy, 1'b0);
    check("post_reset_ready", data_ready, 1'b1);

    // Idle with motor on and no data stays low.
    repeat (30) @(negedge clk);
    check("idle_no_data", casdout, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/cas_fsk_tx.md
CAS_FSK_TX -- requirements
Module: cas_fsk_tx

Interface
REQ-001 SHALL have parameter HALF0, default 17898: clocks per half-cycle of a 0-bit (1200 Hz at 42.954 MHz).
REQ-002 SHALL have parameter HALF1, default 8949: clocks per half-cycle of a 1-bit (2400 Hz).
REQ-003 SHALL have port clk, input, 1: single system clock, 42.954 MHz.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port data_in, input, 8: tape byte to send.
REQ-006 SHALL have port data_valid, input, 1: data_in is valid.
REQ-007 SHALL have port data_ready, output, 1: holding register is empty; a byte is accepted on any edge where data_valid and data_ready are both high.
REQ-008 SHALL have port motor, input, 1: cassette relay (PIA1 CA2); transmission runs only while it is high.
REQ-009 SHALL have port casdout, output, 1: registered FSK tape level into PIA1 port A bit 0.
REQ-010 SHALL have port busy, output, 1: high while a byte is in the holding register or the state is not IDLE.

Function
REQ-011 SHALL double-buffer: one 8-bit holding register and one 8-bit shift register; data_ready = ~hold_full, registered, with no bypass.
REQ-012 SHALL send bits LSB first; each bit is one full cycle: casdout=1 for HALFn clocks, then casdout=0 for HALFn clocks, n = bit value.
REQ-013 SHALL implement an FSM with states IDLE, HIGH and LOW.
REQ-014 IDLE->HIGH when motor=1 and hold_full: move holding to shift, clear hold_full, set bit_idx=0, load the timer with the half-period of bit 0.
REQ-015 HIGH->LOW when the timer expires after exactly HALFn clocks; reload the timer with the same HALFn.
REQ-016 On LOW expiry with bit_idx<7: increment bit_idx, reload the timer for the next bit, go to HIGH.
REQ-017 On LOW expiry with bit_idx=7: if hold_full, load the next byte and go to HIGH with zero gap; otherwise go to IDLE.
REQ-018 Latency: casdout SHALL first read 1 on the 2nd rising edge after the accepting edge, when starting from IDLE with motor=1.
REQ-019 A load and a write cannot coincide: a load requires hold_full and a write requires ~hold_full.
REQ-020 With motor=0 in HIGH or LOW: freeze the timer and bit_idx and force casdout=0; when motor returns to 1, resume with the remaining count of the same half.
REQ-021 The holding register SHALL still accept a byte while motor=0.
REQ-022 The timer SHALL be 15 bits wide; HALF0 and HALF1 SHALL each be ≥2 and ≤32767.

Reset
REQ-023 Reset SHALL asynchronously force state=IDLE, casdout=0, hold_full=0 (data_ready=1), busy=0, bit_idx=0, timer=0 and shift=0.
REQ-024 Reset mid-byte SHALL discard both the shift register and the holding register; no partial cycle resumes after reset.

Configuration
REQ-025 With CAS_LEADER_EN defined: in IDLE, with motor=1 and hold_full=0, the shift register SHALL load LEADER_BYTE (0x55) and transmit it; this repeats until a real byte arrives. Loading a real byte SHALL take priority at each byte boundary.
REQ-026 Without CAS_LEADER_EN: IDLE with no data SHALL hold casdout=0.

Structure
REQ-027 Package cas_pkg SHALL hold the state enum (IDLE/HIGH/LOW), the default HALF0/HALF1 constants, and LEADER_BYTE=8'h55.
REQ-028 Sub-module cas_halfper_timer SHALL provide the loadable 15-bit down-counter with enable (motor) and an expire pulse.

Verification (bench parameters HALF0=4, HALF1=2)
REQ-029 Reset release -> casdout=0, data_ready=1, busy=0.
REQ-030 Send 0x01 with motor=1 -> bit 0: high 2 / low 2 clocks; 7 zero bits: high 4 / low 4 each; 60 clocks total; then IDLE and busy=0.
REQ-031 Back-to-back 0xAA then 0x55 -> data_ready rises 1 clock after the 0xAA load; no idle clock between byte 1 bit 7 low and byte 2 bit 0 high.
REQ-032 Motor dropped for 10 clocks at the 3rd clock of a 0-bit high phase -> casdout=0 during the drop; on resume, 1 remaining high clock, then low 4; total byte duration extended by exactly 10 clocks.
REQ-033 Reset asserted mid-byte with the holding register full -> casdout=0 immediately (asynchronous); after release, data_ready=1 and no further transitions.
REQ-034 CAS_LEADER_EN, motor=1, no data -> repeating 0x55 pattern (alternating 2-clock and 4-clock half-cycles); without the macro, casdout stays 0.
